uart_reg_bridge: RTL

Host-side command engine on the far side of the UART FIFO interface. It pops command bytes from the RX FIFO read port and drives a simple register bus. It pushes response bytes into the TX FIFO write port. The block turns the UART into a byte-level register read/write channel for on-chip control.

---
 rtl/uart_bridge_pkg.sv | 29 ++
 rtl/uart_bridge_timeout.sv | 38 +++
 rtl/uart_reg_bridge.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared types and constants for the UART register bridge
// State encoding, default response bytes and command-byte field helpers.
package uart_bridge_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD_POP,
        CMD_LAT,
        DAT_WAIT,
        DAT_POP,
        DAT_LAT,
        REG_WR,
        REG_RD,
        RD_LAT,
        RESP
    } state_e;

    localparam logic [7:0] DEF_ACK_BYTE = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE = 8'h15;
    localparam int         WR_BIT       = 7;

    // Any set bit between the address field and the write flag makes the command malformed.
    function automatic logic cmd_malformed(input logic [7:0] cmd, input int addr_w);
        logic [6:0] hi;
        hi = cmd[6:0] >> addr_w;
        return hi != 7'd0;
    endfunction

endpackage

// File: rtl/uart_bridge_timeout.sv
// rtl/uart_bridge_timeout.sv - loadable down-counter with terminal-count flag
// Held at TIMEOUT_CYC-1 while load_i is high; tc_o flags the last allowed cycle while enabled.
module uart_bridge_timeout #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte stream to register bus command engine
// Optional data-byte timeout is enabled with macro UART_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int          ADDR_W      = 4,
    parameter int          TIMEOUT_CYC = 100000,
    parameter logic [7:0]  ACK_BYTE    = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE    = DEF_NAK_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rx_rd_en,
    output logic [7:0]        tx_data,
    input  logic              tx_full,
    output logic              tx_wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        resp_q, resp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              armed_q;
    logic              rx_pop;
    logic              timeout_hit;

`ifdef UART_BRIDGE_TIMEOUT_EN
    uart_bridge_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (state_q != DAT_WAIT),
        .en_i    (state_q == DAT_WAIT),
        .tc_o    (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        resp_d  = resp_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rx_pop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_empty && armed_q) begin
                    rx_pop  = 1'b1;
                    state_d = CMD_POP;
                end
            end
            CMD_POP: begin
                cmd_d   = rx_data;
                state_d = CMD_LAT;
            end
            CMD_LAT: begin
                if (cmd_malformed(cmd_q, ADDR_W)) begin
                    resp_d  = NAK_BYTE;
                    state_d = RESP;
                end else begin
                    addr_d  = cmd_q[ADDR_W-1:0];
                    state_d = cmd_q[WR_BIT] ? DAT_WAIT : REG_RD;
                end
            end
            DAT_WAIT: begin
                // An arriving byte beats a timeout landing in the same cycle.
                if (!rx_empty) begin
                    rx_pop  = 1'b1;
                    state_d = DAT_POP;
                end else if (timeout_hit) begin
                    resp_d  = NAK_BYTE;
                    state_d = RESP;
                end
            end
            DAT_POP: begin
                wdata_d = rx_data;
                state_d = DAT_LAT;
            end
            DAT_LAT:  state_d = REG_WR;
            REG_WR: begin
                resp_d  = ACK_BYTE;
                state_d = RESP;
            end
            REG_RD:   state_d = RD_LAT;
            RD_LAT: begin
                resp_d  = reg_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (!tx_full) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // armed_q keeps the combinational pop strobe low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            resp_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            resp_q  <= resp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            armed_q <= 1'b1;
        end
    end

    assign rx_rd_en  = rx_pop;
    assign tx_wr_en  = (state_q == RESP) && !tx_full;
    assign tx_data   = resp_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = (state_q == REG_WR);
    assign reg_rd    = (state_q == REG_RD);
    assign busy      = (state_q != IDLE);

endmodule
